fft_input_sequencer: RTL and testbench

//  Front end of the 32-point radix-2 FFT, directly upstream of the butterfly stage. Accepts
//  one complex sample per handshake, stores a 32-sample frame, then drains it as 4 groups of
//  8 samples (4 butterfly pairs) with the per-pair sel/en strobes the butterfly stage consumes.

---
 rtl/fft_input_sequencer_pkg.sv | 22 ++
 rtl/fft_input_sequencer_if.sv | 12 +
 rtl/fft_input_sequencer.sv | 144 ++++++++++++++
 tb/tb_fft_input_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_input_sequencer_pkg.sv
// Shared constants, FSM state encoding and the 5-bit bit-reverse helper for the FFT input sequencer.
// Bit-reversed (DIT) write ordering is selected by defining FFT_BITREV_EN.
package fft_input_sequencer_pkg;

  localparam int DEF_NUMBER_BITS = 22;
  localparam int N_POINTS        = 32;
  localparam int LOG2N           = 5;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } seq_state_e;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = idx[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_sequencer_if.sv
// Sample-input handshake between an upstream source and the FFT input sequencer.
interface fft_input_sequencer_if
  #(parameter int NUMBER_BITS = fft_input_sequencer_pkg::DEF_NUMBER_BITS);

  logic                     in_valid;
  logic                     in_ready;
  logic [2*NUMBER_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/fft_input_sequencer.sv
// Collects a 32-sample complex frame, then drains it as 4 groups x 4 butterfly pairs with sel/en strobes.
// Build option: define FFT_BITREV_EN to store samples at bit-reversed addresses (DIT input order).
module fft_input_sequencer
  import fft_input_sequencer_pkg::*;
#(
  parameter int NUMBER_BITS = fft_input_sequencer_pkg::DEF_NUMBER_BITS
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  fft_input_sequencer_if.slave     in_bus,
  input  logic                     stall,
  output logic [2*NUMBER_BITS-1:0] out1,
  output logic [2*NUMBER_BITS-1:0] out2,
  output logic [2*NUMBER_BITS-1:0] out3,
  output logic [2*NUMBER_BITS-1:0] out4,
  output logic [2*NUMBER_BITS-1:0] out5,
  output logic [2*NUMBER_BITS-1:0] out6,
  output logic [2*NUMBER_BITS-1:0] out7,
  output logic [2*NUMBER_BITS-1:0] out8,
  output logic [1:0]               sel,
  output logic                     en1,
  output logic                     en2,
  output logic                     en3,
  output logic                     en4,
  output logic [1:0]               grp_idx,
  output logic                     grp_valid,
  output logic                     frame_done
);

  localparam int SW = 2 * NUMBER_BITS;

  seq_state_e       state, state_nxt;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_addr;
  logic [1:0]       grp;
  logic [1:0]       pair;
  logic [SW-1:0]    ram [N_POINTS];
  logic [SW-1:0]    out_p1 [8];
  logic             frame_done_p1;
  logic             accept;
  logic             last_accept;
  logic             issue;
  logic             grp_end;
  logic             last_pair;
  logic             fetch;
  logic [1:0]       fetch_grp;
  logic [3:0]       en_vec;

  assign in_bus.in_ready = (state == ST_LOAD);
  assign accept          = in_bus.in_valid && in_bus.in_ready;
  assign last_accept     = accept && (wr_cnt == LOG2N'(N_POINTS - 1));
  assign issue           = (state == ST_DRAIN) && !stall;
  assign grp_end         = issue && (pair == 2'd3);
  assign last_pair       = grp_end && (grp == 2'd3);

  // Group g+1 is fetched on the edge that retires pair 3 of group g, so it is stable for all 4 pairs.
  assign fetch     = last_accept || (grp_end && (grp != 2'd3));
  assign fetch_grp = last_accept ? 2'd0 : grp + 2'd1;

`ifdef FFT_BITREV_EN
  assign wr_addr = bitrev5(wr_cnt);
`else
  assign wr_addr = wr_cnt;
`endif

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (last_accept) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_pair)   state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Sample store: write-only from the input side, no reset.
  always_ff @(posedge clk_50) begin
    if (accept) begin
      ram[wr_addr] <= in_bus.in_data;
    end
  end

  // Stage p1: counters and registered group samples.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      wr_cnt        <= '0;
      grp           <= '0;
      pair          <= '0;
      frame_done_p1 <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        out_p1[j] <= '0;
      end
    end else begin
      frame_done_p1 <= last_pair;
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (last_accept) begin
        grp  <= '0;
        pair <= '0;
      end else if (issue) begin
        pair <= pair + 2'd1;
        if (pair == 2'd3) begin
          grp <= grp + 2'd1;
        end
      end
      if (fetch) begin
        for (int k = 0; k < 4; k++) begin
          out_p1[k]     <= ram[{fetch_grp, 2'(k), 1'b0}];
          out_p1[k + 4] <= ram[{fetch_grp, 2'(k), 1'b1}];
        end
      end
    end
  end

  // Strobes are masked in the stalled cycle itself; the (g,k) position simply holds.
  assign en_vec = issue ? (4'b0001 << pair) : 4'b0000;

  assign en1        = en_vec[0];
  assign en2        = en_vec[1];
  assign en3        = en_vec[2];
  assign en4        = en_vec[3];
  assign sel        = pair;
  assign grp_idx    = grp;
  assign grp_valid  = issue;
  assign frame_done = frame_done_p1;

  assign out1 = out_p1[0];
  assign out2 = out_p1[1];
  assign out3 = out_p1[2];
  assign out4 = out_p1[3];
  assign out5 = out_p1[4];
  assign out6 = out_p1[5];
  assign out7 = out_p1[6];
  assign out8 = out_p1[7];

endmodule

// File: tb/tb_fft_input_sequencer.sv
// Directed bench for fft_input_sequencer: load/drain ordering, stall, ignored input during drain, reset, sign passthrough.
module tb_fft_input_sequencer;
  import fft_input_sequencer_pkg::*;

  localparam int NB = 22;
  localparam int SW = 2 * NB;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [SW-1:0] out1, out2, out3, out4, out5, out6, out7, out8;
  logic [1:0]    sel, grp_idx;
  logic          en1, en2, en3, en4, grp_valid, frame_done;

  int            tests = 0;
  int            fails = 0;
  logic [SW-1:0] exp_ram [32];
  logic [SW-1:0] seen [4][8];
  logic [SW-1:0] outs [8];
  logic [3:0]    en_vec;

  fft_input_sequencer_if #(.NUMBER_BITS(NB)) bus ();

  fft_input_sequencer #(.NUMBER_BITS(NB)) dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .in_bus     (bus),
    .stall      (stall),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7),
    .out8       (out8),
    .sel        (sel),
    .en1        (en1),
    .en2        (en2),
    .en3        (en3),
    .en4        (en4),
    .grp_idx    (grp_idx),
    .grp_valid  (grp_valid),
    .frame_done (frame_done)
  );

  always #10 clk_50 = ~clk_50;

  assign outs[0] = out1;
  assign outs[1] = out2;
  assign outs[2] = out3;
  assign outs[3] = out4;
  assign outs[4] = out5;
  assign outs[5] = out6;
  assign outs[6] = out7;
  assign outs[7] = out8;
  assign en_vec  = {en4, en3, en2, en1};

  function automatic logic [4:0] addr_of(input int i);
    logic [4:0] v;
    logic [4:0] r;
    v = i[4:0];
`ifdef FFT_BITREV_EN
    for (int b = 0; b < 5; b++) r[b] = v[4-b];
`else
    r = v;
`endif
    return r;
  endfunction

  function automatic logic [SW-1:0] smp(input int re, input int im);
    return {re[NB-1:0], im[NB-1:0]};
  endfunction

  function automatic logic [SW-1:0] gen(input int kind, input int i);
    case (kind)
      0:       return smp(i, 0);
      1:       return smp(-1 - i, -2097152 + i);
      default: return smp(100 + i, 7);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic send_frame(input int kind, input int count);
    for (int i = 0; i < count; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = gen(kind, i);
      #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL load_ready i=%0d got %b want 1", i, bus.in_ready);
      end
      exp_ram[addr_of(i)] = gen(kind, i);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Walks the 16 pair cycles (plus optional stall cycles at (sg,sk)) and ends in the frame_done cycle.
  task automatic drain(input int sg, input int sk, input int sn, input logic hold_valid);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (g == sg && k == sk) begin
          for (int s = 0; s < sn; s++) begin
            stall = 1'b1;
            #1;
            tests++;
            if (en_vec !== 4'b0000 || grp_valid !== 1'b0) begin
              fails++;
              $display("FAIL stall_strobes g=%0d k=%0d got en=%b vld=%b want en=0000 vld=0", g, k, en_vec, grp_valid);
            end
            tests++;
            if (sel !== 2'(k) || grp_idx !== 2'(g)) begin
              fails++;
              $display("FAIL stall_hold g=%0d k=%0d got sel=%0d grp=%0d", g, k, sel, grp_idx);
            end
            tests++;
            if (outs[0] !== exp_ram[8*g] || outs[7] !== exp_ram[8*g+7]) begin
              fails++;
              $display("FAIL stall_data g=%0d got %h/%h want %h/%h", g, outs[0], outs[7], exp_ram[8*g], exp_ram[8*g+7]);
            end
            tick();
          end
        end
        stall = 1'b0;
        if (hold_valid) begin
          bus.in_valid = 1'b1;
          bus.in_data  = smp(32'h003FFFFF, 0);
        end
        #1;
        tests++;
        if (grp_valid !== 1'b1 || en_vec !== (4'b0001 << k)) begin
          fails++;
          $display("FAIL pair_strobes g=%0d k=%0d got en=%b vld=%b want en=%b vld=1", g, k, en_vec, grp_valid, 4'b0001 << k);
        end
        tests++;
        if (sel !== 2'(k) || grp_idx !== 2'(g)) begin
          fails++;
          $display("FAIL pair_index g=%0d k=%0d got sel=%0d grp=%0d", g, k, sel, grp_idx);
        end
        tests++;
        if (frame_done !== 1'b0 || bus.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL drain_ctrl g=%0d k=%0d got done=%b rdy=%b want 0/0", g, k, frame_done, bus.in_ready);
        end
        for (int j = 0; j < 4; j++) begin
          tests++;
          if (outs[j] !== exp_ram[8*g+2*j] || outs[j+4] !== exp_ram[8*g+2*j+1]) begin
            fails++;
            $display("FAIL pair_data g=%0d k=%0d j=%0d got y=%h x=%h want y=%h x=%h", g, k, j,
                     outs[j], outs[j+4], exp_ram[8*g+2*j], exp_ram[8*g+2*j+1]);
          end
        end
        for (int j = 0; j < 8; j++) seen[g][j] = outs[j];
        tick();
      end
    end
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (frame_done !== 1'b1 || en_vec !== 4'b0000 || grp_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL frame_done got done=%b en=%b vld=%b rdy=%b want 1/0000/0/1", frame_done, en_vec, grp_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if (bus.in_ready !== 1'b1 || en_vec !== 4'b0000 || grp_valid !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got rdy=%b en=%b vld=%b done=%b", bus.in_ready, en_vec, grp_valid, frame_done);
    end
    tests++;
    if (sel !== 2'd0 || grp_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset_idx got sel=%0d grp=%0d want 0/0", sel, grp_idx);
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if (outs[j] !== '0) begin
        fails++;
        $display("FAIL reset_out%0d got %h want 0", j + 1, outs[j]);
      end
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.in_ready !== 1'b1 || grp_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got rdy=%b vld=%b want 1/0", bus.in_ready, grp_valid);
    end
  endtask

  task automatic test_ordering();
    logic [SW-1:0] h [8];
`ifdef FFT_BITREV_EN
    h = '{{22'd0, 22'd0}, {22'd16, 22'd0}, {22'd8, 22'd0}, {22'd24, 22'd0},
          {22'd3, 22'd0}, {22'd19, 22'd0}, {22'd15, 22'd0}, {22'd31, 22'd0}};
`else
    h = '{{22'd0, 22'd0}, {22'd1, 22'd0}, {22'd2, 22'd0}, {22'd3, 22'd0},
          {22'd24, 22'd0}, {22'd25, 22'd0}, {22'd30, 22'd0}, {22'd31, 22'd0}};
`endif
    send_frame(0, 32);
    drain(-1, -1, 0, 1'b0);
    tests++;
    if (seen[0][0] !== h[0] || seen[0][4] !== h[1] || seen[0][1] !== h[2] || seen[0][5] !== h[3]) begin
      fails++;
      $display("FAIL order_grp0 got %h %h %h %h want %h %h %h %h", seen[0][0], seen[0][4], seen[0][1], seen[0][5],
               h[0], h[1], h[2], h[3]);
    end
    tests++;
    if (seen[3][0] !== h[4] || seen[3][4] !== h[5] || seen[3][3] !== h[6] || seen[3][7] !== h[7]) begin
      fails++;
      $display("FAIL order_grp3 got %h %h %h %h want %h %h %h %h", seen[3][0], seen[3][4], seen[3][3], seen[3][7],
               h[4], h[5], h[6], h[7]);
    end
  endtask

  task automatic test_stall();
    send_frame(2, 32);
    drain(1, 2, 3, 1'b0);
  endtask

  task automatic test_valid_during_drain();
    send_frame(0, 32);
    drain(-1, -1, 0, 1'b1);
    send_frame(2, 32);
    drain(-1, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(1, 17);
    rst_n = 1'b0;
    tick();
    tests++;
    if (bus.in_ready !== 1'b1 || en_vec !== 4'b0000 || grp_valid !== 1'b0 || frame_done !== 1'b0 ||
        sel !== 2'd0 || grp_idx !== 2'd0) begin
      fails++;
      $display("FAIL midreset_ctrl got rdy=%b en=%b vld=%b done=%b sel=%0d grp=%0d",
               bus.in_ready, en_vec, grp_valid, frame_done, sel, grp_idx);
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if (outs[j] !== '0) begin
        fails++;
        $display("FAIL midreset_out%0d got %h want 0", j + 1, outs[j]);
      end
    end
    rst_n = 1'b1;
    tick();
    send_frame(0, 32);
    drain(-1, -1, 0, 1'b0);
  endtask

  task automatic test_negative();
    send_frame(1, 32);
    drain(-1, -1, 0, 1'b0);
    tests++;
    if (seen[0][0] !== {22'h3FFFFF, 22'h200000}) begin
      fails++;
      $display("FAIL neg_first got %h want %h", seen[0][0], {22'h3FFFFF, 22'h200000});
    end
    tests++;
    if (seen[3][7] !== {22'h3FFFE0, 22'h20001F}) begin
      fails++;
      $display("FAIL neg_last got %h want %h", seen[3][7], {22'h3FFFE0, 22'h20001F});
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    stall        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 32; i++) exp_ram[i] = '0;
    test_reset();
    test_ordering();
    test_stall();
    test_valid_during_drain();
    test_reset_mid_frame();
    test_negative();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
